// File: rtl/pomodoro_pkg.sv
// Shared constants, button indices and helper functions for the pomodoro controller.
package pomodoro_pkg;

   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_6 = 7'b0000010;
   localparam logic [6:0] SEG_7 = 7'b1111000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam int MAX_MIN_DEFAULT = 99;

   typedef enum logic [1:0] {
      INC5 = 2'd0,
      DEC5 = 2'd1,
      INC1 = 2'd2,
      DEC1 = 2'd3
   } btn_e;

   function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

   function automatic logic is_onehot4(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

endpackage

// File: rtl/pomodoro_tick.sv
// Free-running 1 s tick: one-clk pulse every CLK_HZ cycles, registered.
module pomodoro_tick #(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_HZ - 1);
   localparam logic [CW-1:0] CNT_PRE  = CW'(CLK_HZ - 2);

   logic [CW-1:0] cnt_r;

   // Counter wraps at CLK_HZ-1; the pulse is registered one count early so it lines up with the wrap
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= {CW{1'b0}};
         tick  <= 1'b0;
      end else begin
         if (cnt_r == CNT_LAST) begin
            cnt_r <= {CW{1'b0}};
         end else begin
            cnt_r <= cnt_r + CW'(1);
         end
         tick <= (cnt_r == CNT_PRE);
      end
   end

endmodule

// File: rtl/pomodoro_ctrl.sv
// Pomodoro MM:SS countdown with tick-sampled button debounce, minute adjust and 7-seg decode.
module pomodoro_ctrl
   import pomodoro_pkg::*;
#(
   parameter int CLK_HZ  = 50_000_000,
   parameter int MAX_MIN = MAX_MIN_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       swPlayPause,
   input  logic       bIncrementa5,
   input  logic       bDecrementa5,
   input  logic       bIncrementa1,
   input  logic       bDecrementa1,
   output logic       timedClk,
   output logic       e1,
   output logic       e2,
   output logic       e3,
   output logic       e4,
   output logic [6:0] displayUnidadeSegundos,
   output logic [6:0] displayDezenaSegundos,
   output logic [6:0] displayUnidadeMinutos,
   output logic [6:0] displayDezenaMinuto
);

   logic       tick;
   logic [3:0] btn_s;
   logic [3:0] sync1_r;
   logic [3:0] sync2_r;
   logic [3:0] hist0_r;
   logic [3:0] hist1_r;
   logic [3:0] armed_r;
   logic [3:0] qual_s;
   logic [3:0] accept_s;
   logic [3:0] flag_r;
   logic       play_prev_r;
   logic [6:0] min_r;
   logic [6:0] min_nxt_s;
   logic [5:0] sec_r;
   logic [5:0] sec_nxt_s;

   function automatic logic [6:0] add_min(input logic [6:0] m, input logic [6:0] k);
      logic [7:0] sum;
      sum = {1'b0, m} + {1'b0, k};
      if (sum > 8'(MAX_MIN)) begin
         return 7'(MAX_MIN);
      end else begin
         return sum[6:0];
      end
   endfunction

   pomodoro_tick #(.CLK_HZ(CLK_HZ)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   assign timedClk = tick;

   // Gather buttons into a vector indexed by button kind
   always_comb begin
      btn_s       = 4'd0;
      btn_s[INC5] = bIncrementa5;
      btn_s[DEC5] = bDecrementa5;
      btn_s[INC1] = bIncrementa1;
      btn_s[DEC1] = bDecrementa1;
   end

   // armed blocks a button held through reset until a real low sample is seen
   assign qual_s = sync2_r & hist0_r & ~hist1_r & armed_r;

   // Only a single qualifying button, in set mode, on a tick is applied
   always_comb begin
      if (tick && !swPlayPause && is_onehot4(qual_s)) begin
         accept_s = qual_s;
      end else begin
         accept_s = 4'd0;
      end
   end

   // Next-time computation: countdown in run mode, minute adjust in set mode
   always_comb begin
      min_nxt_s = min_r;
      sec_nxt_s = sec_r;
      if (tick && swPlayPause) begin
         if (sec_r != 6'd0) begin
            sec_nxt_s = sec_r - 6'd1;
         end else if (min_r != 7'd0) begin
            min_nxt_s = min_r - 7'd1;
            sec_nxt_s = 6'd59;
         end else begin
            min_nxt_s = 7'd0;
            sec_nxt_s = 6'd0;
         end
      end else if (accept_s[INC5]) begin
         min_nxt_s = add_min(min_r, 7'd5);
      end else if (accept_s[INC1]) begin
         min_nxt_s = add_min(min_r, 7'd1);
      end else if (accept_s[DEC5]) begin
         if (min_r >= 7'd5) begin
            min_nxt_s = min_r - 7'd5;
         end else begin
            min_nxt_s = 7'd0;
            sec_nxt_s = 6'd0;
         end
      end else if (accept_s[DEC1]) begin
         if (min_r >= 7'd1) begin
            min_nxt_s = min_r - 7'd1;
         end else begin
            min_nxt_s = 7'd0;
            sec_nxt_s = 6'd0;
         end
      end else begin
         min_nxt_s = min_r;
         sec_nxt_s = sec_r;
      end
   end

   // Button synchronizers and per-tick sample history
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_r <= 4'd0;
         sync2_r <= 4'd0;
         hist0_r <= 4'd0;
         hist1_r <= 4'd0;
         armed_r <= 4'd0;
      end else begin
         sync1_r <= btn_s;
         sync2_r <= sync1_r;
         if (tick) begin
            hist0_r <= sync2_r;
            hist1_r <= hist0_r;
            armed_r <= armed_r | ~sync2_r;
         end
      end
   end

   // Time register and acknowledge flags; flags clear on entry to run mode
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         min_r       <= 7'd0;
         sec_r       <= 6'd0;
         flag_r      <= 4'd0;
         play_prev_r <= 1'b0;
      end else begin
         min_r       <= min_nxt_s;
         sec_r       <= sec_nxt_s;
         play_prev_r <= swPlayPause;
         if (swPlayPause && !play_prev_r) begin
            flag_r <= 4'd0;
         end else begin
            flag_r <= flag_r | accept_s;
         end
      end
   end

   assign e1 = flag_r[INC5];
   assign e2 = flag_r[DEC5];
   assign e3 = flag_r[INC1];
   assign e4 = flag_r[DEC1];

   // BCD split of the time register straight into the segment decoders
   always_comb begin
      displayDezenaMinuto    = bcd_to_seg(4'(min_r / 7'd10));
      displayUnidadeMinutos  = bcd_to_seg(4'(min_r % 7'd10));
      displayDezenaSegundos  = bcd_to_seg(4'(sec_r / 6'd10));
      displayUnidadeSegundos = bcd_to_seg(4'(sec_r % 6'd10));
   end

endmodule

// File: tb/tb_pomodoro_ctrl.sv
// Self-checking bench for pomodoro_ctrl: seconds-based reference model, directed scenarios, random stimulus.
module tb_pomodoro_ctrl;

   localparam int HZ   = 4;
   localparam int MAXM = 99;

   logic       clk;
   logic       rst;
   logic       sw;
   logic [3:0] btns;   // bit0 +5, bit1 -5, bit2 +1, bit3 -1
   logic       timedClk, e1, e2, e3, e4;
   logic [6:0] dsu, dst, dmu, dmt;

   pomodoro_ctrl #(.CLK_HZ(HZ), .MAX_MIN(MAXM)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .swPlayPause            (sw),
      .bIncrementa5           (btns[0]),
      .bDecrementa5           (btns[1]),
      .bIncrementa1           (btns[2]),
      .bDecrementa1           (btns[3]),
      .timedClk               (timedClk),
      .e1                     (e1),
      .e2                     (e2),
      .e3                     (e3),
      .e4                     (e4),
      .displayUnidadeSegundos (dsu),
      .displayDezenaSegundos  (dst),
      .displayUnidadeMinutos  (dmu),
      .displayDezenaMinuto    (dmt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // reference model: time as total seconds, buttons as runs of 1-samples per tick
   int m_time;
   int m_cnt;
   bit m_tick;
   int m_ticks = 0;
   bit m_flag [4];
   bit m_play_prev;
   int m_run [4];
   bit m_seen_low [4];
   bit m_pipe1 [4];
   bit m_pipe2 [4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      int mins, secs, nq, pick;
      bit q;
      if (rst) begin
         m_time = 0; m_cnt = 0; m_tick = 1'b0; m_play_prev = 1'b0;
         for (int b = 0; b < 4; b++) begin
            m_flag[b] = 1'b0; m_run[b] = 0; m_seen_low[b] = 1'b0;
            m_pipe1[b] = 1'b0; m_pipe2[b] = 1'b0;
         end
         return;
      end
      if (m_tick) begin
         m_ticks++;
         nq = 0; pick = 0;
         for (int b = 0; b < 4; b++) begin
            q = 1'b0;
            if (m_pipe2[b]) begin
               m_run[b]++;
               q = (m_run[b] == 2) && m_seen_low[b];
            end else begin
               m_run[b] = 0;
               m_seen_low[b] = 1'b1;
            end
            if (q) begin nq++; pick = b; end
         end
         if (sw) begin
            if (m_time > 0) m_time--;
         end else if (nq == 1) begin
            mins = m_time / 60; secs = m_time % 60;
            case (pick)
               0: mins = (mins + 5 > MAXM) ? MAXM : mins + 5;
               1: if (mins >= 5) mins -= 5; else begin mins = 0; secs = 0; end
               2: mins = (mins + 1 > MAXM) ? MAXM : mins + 1;
               default: if (mins >= 1) mins -= 1; else begin mins = 0; secs = 0; end
            endcase
            m_time = mins * 60 + secs;
            m_flag[pick] = 1'b1;
         end
      end
      if (sw && !m_play_prev) for (int b = 0; b < 4; b++) m_flag[b] = 1'b0;
      m_play_prev = sw;
      for (int b = 0; b < 4; b++) begin
         m_pipe2[b] = m_pipe1[b];
         m_pipe1[b] = btns[b];
      end
      m_cnt  = (m_cnt + 1) % HZ;
      m_tick = (m_cnt == HZ - 1);
   endtask

   task automatic compare();
      int mins, secs;
      mins = m_time / 60; secs = m_time % 60;
      check("display", {dmt, dmu, dst, dsu},
            {seg_tab[mins / 10], seg_tab[mins % 10], seg_tab[secs / 10], seg_tab[secs % 10]});
      check("flags", {timedClk, e4, e3, e2, e1},
            {m_tick, m_flag[3], m_flag[2], m_flag[1], m_flag[0]});
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (chk_en) compare();
   end

   task automatic wait_ticks(input int n);
      int target, guard;
      target = m_ticks + n;
      guard  = 0;
      while (m_ticks < target && guard < (n + 2) * HZ) begin
         @(posedge clk); #1;
         guard++;
      end
      if (m_ticks < target) check("tick_timeout", m_ticks, target);
   endtask

   task automatic press(input logic [3:0] mask);
      @(negedge clk); #1;
      btns = mask;
      wait_ticks(3);
      @(negedge clk); #1;
      btns = 4'b0000;
      wait_ticks(3);
   endtask

   task automatic set_sw(input logic v);
      @(negedge clk); #1;
      sw = v;
   endtask

   task automatic expect_time(input string name, input int mm, input int ss);
      check({name, "_model"}, m_time, mm * 60 + ss);
      check({name, "_disp"}, {dmt, dmu, dst, dsu},
            {seg_tab[mm / 10], seg_tab[mm % 10], seg_tab[ss / 10], seg_tab[ss % 10]});
   endtask

   initial begin
      int rst_hold;
      rst  = 1'b1;
      sw   = 1'bx;
      btns = 4'bxxxx;
      #2;
      sw   = 1'b0;
      btns = 4'b0000;
      repeat (3) @(posedge clk);
      #1;
      chk_en = 1'b1;
      check("rst_disp", {dmt, dmu, dst, dsu}, {4{7'b1000000}});
      check("rst_flags", {timedClk, e4, e3, e2, e1}, 5'b00000);
      @(negedge clk); #1;
      rst = 1'b0;
      wait_ticks(2);

      press(4'b0001);
      check("inc5_min_units", dmu, 7'b0010010);
      check("inc5_others", {dmt, dst, dsu}, {3{7'b1000000}});
      check("inc5_e1", {e4, e3, e2, e1}, 4'b0001);
      expect_time("inc5", 5, 0);
      press(4'b0001);
      expect_time("inc5_twice", 10, 0);
      check("ten_min_tens", dmt, 7'b1111001);
      press(4'b0010);
      press(4'b0010);
      expect_time("dec5_to_zero", 0, 0);
      check("dec5_flags", {e4, e3, e2, e1}, 4'b0011);
      press(4'b0100);
      expect_time("inc1", 1, 0);
      press(4'b1000);
      expect_time("dec1", 0, 0);
      press(4'b1000);
      expect_time("dec1_floor", 0, 0);
      check("all_flags", {e4, e3, e2, e1}, 4'b1111);

      press(4'b0100);
      set_sw(1'b1);
      @(posedge clk); #1;
      check("run_clears_flags", {e4, e3, e2, e1}, 4'b0000);
      wait_ticks(1);
      check("run_sec_tens", dst, 7'b0010010);
      check("run_sec_units", dsu, 7'b0010000);
      expect_time("run_one_tick", 0, 59);
      press(4'b0001);
      press(4'b1000);
      wait_ticks(60);
      expect_time("run_expired", 0, 0);
      wait_ticks(3);
      expect_time("run_hold", 0, 0);

      set_sw(1'b0);
      press(4'b0101);
      expect_time("simultaneous", 0, 0);
      check("simultaneous_flags", {e4, e3, e2, e1}, 4'b0000);
      for (int i = 0; i < 19; i++) press(4'b0001);
      press(4'b0100);
      press(4'b0100);
      expect_time("at_97", 97, 0);
      press(4'b0001);
      expect_time("sat_99", 99, 0);
      check("sat_99_tens", dmt, 7'b0010000);

      @(negedge clk); #1;
      rst  = 1'b1;
      btns = 4'b0100;
      @(posedge clk); #1;
      expect_time("mid_reset", 0, 0);
      @(negedge clk); #1;
      rst = 1'b0;
      wait_ticks(4);
      expect_time("held_through_reset", 0, 0);
      check("held_through_reset_e3", e3, 1'b0);
      @(negedge clk); #1;
      btns = 4'b0000;
      wait_ticks(3);
      press(4'b0100);
      expect_time("after_release", 1, 0);
      set_sw(1'b1);
      wait_ticks(30);
      expect_time("pause_point", 0, 30);
      set_sw(1'b0);
      wait_ticks(5);
      expect_time("paused_hold", 0, 30);
      set_sw(1'b1);
      wait_ticks(1);
      expect_time("resume", 0, 29);

      rst_hold = 0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk); #1;
         if (rst) begin
            if (rst_hold == 0) rst = 1'b0;
            else rst_hold--;
         end else if ($urandom_range(0, 1499) == 0) begin
            rst = 1'b1;
            rst_hold = 2;
         end else begin
            if ($urandom_range(0, 299) == 0) sw = ~sw;
            for (int b = 0; b < 4; b++) begin
               if ($urandom_range(0, 9) == 0) btns[b] = ~btns[b];
            end
         end
      end
      @(negedge clk); #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
